// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants, read FSM encoding and zigzag lookup for dct_zigzag_quant
package dct_pkg;

    localparam int N_COEF = 16;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Maps zigzag position to the raster address of a 4x4 block.
    function automatic logic [3:0] zz_addr(input logic [3:0] idx);
        logic [3:0] a;
        case (idx)
            4'd0:    a = 4'd0;
            4'd1:    a = 4'd1;
            4'd2:    a = 4'd4;
            4'd3:    a = 4'd8;
            4'd4:    a = 4'd5;
            4'd5:    a = 4'd2;
            4'd6:    a = 4'd3;
            4'd7:    a = 4'd6;
            4'd8:    a = 4'd9;
            4'd9:    a = 4'd12;
            4'd10:   a = 4'd13;
            4'd11:   a = 4'd10;
            4'd12:   a = 4'd7;
            4'd13:   a = 4'd11;
            4'd14:   a = 4'd14;
            default: a = 4'd15;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/dct_quant_round.sv
// rtl/dct_quant_round.sv - combinational sign-magnitude round-half-up right shift
module dct_quant_round #(
    parameter int COEF_W = 16
) (
    input  logic signed [COEF_W-1:0] x,
    input  logic        [2:0]        s,
    output logic signed [COEF_W-1:0] y
);

    localparam logic [COEF_W:0]   ONE_W1 = {{COEF_W{1'b0}}, 1'b1};
    localparam logic [COEF_W-1:0] ONE_W  = {{(COEF_W-1){1'b0}}, 1'b1};

    logic [COEF_W:0]   ext;
    logic [COEF_W:0]   mag;
    logic [COEF_W:0]   half;
    logic [COEF_W-1:0] rnd;
    logic [COEF_W-1:0] neg;

    // Magnitude is one bit wider so the most negative input negates cleanly.
    always_comb begin
        ext  = {x[COEF_W-1], x};
        mag  = x[COEF_W-1] ? (~ext + ONE_W1) : ext;
        half = (s == 3'd0) ? '0 : (ONE_W1 << (s - 3'd1));
        rnd  = COEF_W'((mag + half) >> s);
        neg  = ~rnd + ONE_W;
        if (s == 3'd0) begin
            y = x;
        end else begin
            y = x[COEF_W-1] ? neg : rnd;
        end
    end

endmodule

// File: rtl/dct_zigzag_quant.sv
// rtl/dct_zigzag_quant.sv - ping-pong 4x4 block buffer with zigzag readout and rounding quantiser
module dct_zigzag_quant import dct_pkg::*; #(
    parameter int COEF_W = 16,
    parameter int N_COEF = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [COEF_W-1:0] coef_in,
    input  logic                     wen,
    output logic                     in_ready,
    input  logic        [2:0]        qshift,
    output logic signed [COEF_W-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic        [3:0]        dout_idx,
    output logic                     dout_last
);

    logic [COEF_W-1:0] mem_q [2][N_COEF];

    logic              wr_bank_q, wr_bank_d;
    logic [3:0]        wr_cnt_q, wr_cnt_d;
    logic [1:0]        full_q, full_d;
    logic              rd_bank_q, rd_bank_d;
    logic [3:0]        rd_idx_q, rd_idx_d;
    rd_state_e         state_q, state_d;
    logic [2:0]        qshift_q, qshift_d;
    logic [COEF_W-1:0] dout_q, dout_d;
    logic [3:0]        idx_q, idx_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;

    logic              wr_fire;
    logic              load;
    logic              ld_bank;
    logic [3:0]        ld_idx;
    logic [2:0]        ld_shift;
    logic [COEF_W-1:0] rd_coef;
    logic [COEF_W-1:0] q_coef;

    assign in_ready = !full_q[wr_bank_q];
    assign wr_fire  = wen && in_ready;
    assign rd_coef  = mem_q[ld_bank][zz_addr(ld_idx)];

    dct_quant_round #(.COEF_W(COEF_W)) u_quant (
        .x (rd_coef),
        .s (ld_shift),
        .y (q_coef)
    );

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        full_d    = full_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        state_d   = state_q;
        qshift_d  = qshift_q;
        dout_d    = dout_q;
        idx_d     = idx_q;
        last_d    = last_q;
        valid_d   = valid_q;
        load      = 1'b0;
        ld_bank   = rd_bank_q;
        ld_idx    = rd_idx_q;
        ld_shift  = qshift_q;

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'(N_COEF - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // A block entering readout uses the live qshift for its first coefficient and latches it for the rest.
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    load     = 1'b1;
                    ld_idx   = 4'd0;
                    ld_shift = qshift;
                    qshift_d = qshift;
                    state_d  = RD_STREAM;
                end
            end
            default: begin
                if (dout_ready) begin
                    if (last_q) begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        if (full_q[~rd_bank_q]) begin
                            load     = 1'b1;
                            ld_bank  = ~rd_bank_q;
                            ld_idx   = 4'd0;
                            ld_shift = qshift;
                            qshift_d = qshift;
                        end else begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            state_d = RD_IDLE;
                        end
                    end else begin
                        load = 1'b1;
                    end
                end
            end
        endcase

        if (load) begin
            rd_idx_d = ld_idx + 4'd1;
            dout_d   = q_coef;
            idx_d    = ld_idx;
            last_d   = (ld_idx == 4'(N_COEF - 1));
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_cnt_q] <= coef_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= 4'd0;
            full_q    <= 2'b00;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= 4'd0;
            state_q   <= RD_IDLE;
            qshift_q  <= 3'd0;
            dout_q    <= '0;
            idx_q     <= 4'd0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            full_q    <= full_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
            state_q   <= state_d;
            qshift_q  <= qshift_d;
            dout_q    <= dout_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_idx   = idx_q;
    assign dout_last  = last_q;
    assign dout_valid = valid_q;

endmodule

// File: tb/tb_dct_zigzag_quant.sv
// tb/tb_dct_zigzag_quant.sv - scoreboard bench for dct_zigzag_quant
module tb_dct_zigzag_quant;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] coef_in = '0;
    logic               wen = 1'b0;
    logic               in_ready;
    logic        [2:0]  qshift = 3'd0;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_ready = 1'b0;
    logic        [3:0]  dout_idx;
    logic               dout_last;

    dct_zigzag_quant #(.COEF_W(16), .N_COEF(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_in    (coef_in),
        .wen        (wen),
        .in_ready   (in_ready),
        .qshift     (qshift),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_idx   (dout_idx),
        .dout_last  (dout_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int idx;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   zz_t[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
    int   cur_blk[16];
    int   cnt = 0;
    bit   hand_mode = 0;
    int   hand_exp[16];
    bit   gap_en = 0;
    bit   gap_arm = 0;

    task automatic chk(input string name, input integer act, input integer req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int qref(input int x, input int s);
        int m, r;
        if (s == 0) return x;
        m = (x < 0) ? -x : x;
        r = (m + (1 << (s - 1))) >> s;
        return (x < 0) ? -r : r;
    endfunction

    task automatic push_block();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.d    = hand_mode ? hand_exp[i] : qref(cur_blk[zz_t[i]], int'(qshift));
            e.idx  = i;
            e.last = (i == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic offer(input int v, output bit acc);
        coef_in = 16'(v);
        wen     = 1'b1;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        wen = 1'b0;
        if (acc) begin
            cur_blk[cnt] = v;
            cnt++;
            if (cnt == 16) begin
                push_block();
                cnt = 0;
            end
        end
    endtask

    task automatic send(input int v);
        bit acc;
        acc = 0;
        for (int t = 0; t < 300 && !acc; t++) offer(v, acc);
        if (!acc) chk("write_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (gap_arm) begin
                gap_arm = 0;
                chk("no_gap_valid", dout_valid, 1);
                chk("no_gap_idx", dout_idx, 0);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", dout, e.d);
                    chk("dout_idx", dout_idx, e.idx);
                    chk("dout_last", dout_last, e.last);
                    if (gap_en && dout_last && exp_q.size() != 0) gap_arm = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        bit acc;
        logic signed [15:0] r16;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", dout_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dout", dout, 0);
        chk("rst_idx", dout_idx, 0);
        chk("rst_last", dout_last, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Raster ramp, no quantisation, latency of one cycle
        dout_ready = 1'b1;
        qshift     = 3'd0;
        for (int k = 0; k < 16; k++) send(k);
        chk("lat_valid_low", dout_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid_high", dout_valid, 1);
        chk("lat_first_idx", dout_idx, 0);
        drain();

        // Hand-computed rounding cases
        qshift    = 3'd2;
        hand_exp  = '{1, -1, 2, -2, 2, -8192, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        hand_mode = 1;
        for (int k = 0; k < 16; k++) begin
            case (k)
                0:       send(5);
                1:       send(-5);
                4:       send(6);
                8:       send(-6);
                5:       send(7);
                2:       send(-32768);
                default: send(0);
            endcase
        end
        hand_mode = 0;
        drain();

        // Backpressure: both banks fill, output held, then drain with no bubble
        qshift     = 3'd0;
        dout_ready = 1'b0;
        acc_cnt    = 0;
        for (int k = 0; k < 48; k++) begin
            offer((k < 16) ? 100 + k : 200 + k - 16, acc);
            if (acc) acc_cnt++;
        end
        chk("bp_accepted", acc_cnt, 32);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid", dout_valid, 1);
        chk("bp_dout", dout, 100);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_hold_dout", dout, 100);
        chk("bp_hold_idx", dout_idx, 0);
        gap_en     = 1;
        dout_ready = 1'b1;
        drain();
        gap_en = 0;

        // Random stalls over four back-to-back blocks
        qshift = 3'd3;
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    for (int k = 0; k < 16; k++) begin
                        r16 = 16'($urandom);
                        send(int'(r16));
                    end
                end
            end
            begin
                for (int c = 0; c < 400 && !(exp_q.size() != 0 && cnt == 0 && n_checks > 0 && c > 80); c++) begin
                    @(posedge clk);
                    #1;
                    dout_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        dout_ready = 1'b1;
        drain();

        // Reset mid-block discards buffered and partial data
        qshift     = 3'd0;
        dout_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(300 + k);
        for (int k = 0; k < 9; k++) send(400 + k);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        cnt = 0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        dout_ready = 1'b1;
        for (int k = 0; k < 16; k++) send(500 + k);
        drain();

        // qshift change mid-block does not affect that block
        qshift = 3'd1;
        for (int k = 0; k < 16; k++) send(k * 7 - 50);
        acc = 0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = dout_valid && (dout_idx == 4'd5);
        end
        chk("qs_reach_idx5", acc, 1);
        qshift = 3'd3;
        drain();

        repeat (3) @(posedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dct_zigzag_quant.md
DCT_ZIGZAG_QUANT -- requirements
Module: dct_zigzag_quant

Interface
REQ-001 SHALL have parameter COEF_W, default 16, meaning width of one signed DCT coefficient.
REQ-002 SHALL have parameter N_COEF, default 16, meaning coefficients per 4x4 block (fixed; other values unsupported).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port coef_in  input  COEF_W  signed coefficient from the DCT stage, raster order (row-major).
REQ-006 SHALL have port wen  input  1  coef_in valid; the write is accepted on a rising edge when wen && in_ready.
REQ-007 SHALL have port in_ready  output  1  input bank available for writes.
REQ-008 SHALL have port qshift  input  3  quantiser right-shift amount, 0..7.
REQ-009 SHALL have port dout  output  COEF_W  quantised coefficient, zigzag order.
REQ-010 SHALL have port dout_valid  output  1  dout holds a valid coefficient.
REQ-011 SHALL have port dout_ready  input  1  consumer accepts dout on a rising edge when dout_valid && dout_ready.
REQ-012 SHALL have port dout_idx  output  4  zigzag position (0..15) of the current dout.
REQ-013 SHALL have port dout_last  output  1  high with dout_idx == 15.

Function
REQ-014 SHALL buffer coefficients in two banks (ping-pong) of 16 x COEF_W; the write side fills one bank while the read side drains the other.
REQ-015 SHALL store each accepted write at raster address wr_cnt (0..15) of the write bank; wr_cnt increments per accepted write and wraps 15->0.
REQ-016 SHALL mark the write bank full on the edge accepting raster address 15, then switch the write bank.
REQ-017 SHALL drive in_ready = !full[write bank] combinationally from registered flags; writes while in_ready is low SHALL be ignored, and wr_cnt SHALL not advance.
REQ-018 SHALL implement read FSM states IDLE and STREAM; IDLE->STREAM on the edge after a bank is full and the read side is idle; STREAM->IDLE on the edge accepting dout_last unless the other bank is already full, in which case it SHALL stay in STREAM with rd_idx = 0 on the other bank (no bubble).
REQ-019 SHALL read raster addresses in zigzag order 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15 for rd_idx 0..15.
REQ-020 SHALL latch qshift when a bank enters readout; qshift changes mid-block SHALL not affect that block.
REQ-021 SHALL quantise: s = 0 -> dout = x; s > 0 -> dout = sign(x) * ((|x| + 2^(s-1)) >> s), with |x| computed at COEF_W+1 bits so x = -2^(COEF_W-1) is correct; result always fits in COEF_W.
REQ-022 SHALL register dout, dout_idx and dout_last; first dout_valid SHALL rise one cycle after the edge that filled the bank (latency 1 from the last write to the first output).
REQ-023 SHALL hold dout, dout_idx, dout_last and dout_valid stable while dout_valid && !dout_ready.
REQ-024 SHALL clear the drained bank's full flag on the edge accepting dout_last; in_ready for that bank SHALL rise the following cycle.
REQ-025 SHALL sustain one coefficient per cycle on each side when dout_ready is held high.
REQ-026 SHALL make a simultaneous 16th write on one bank and dout_last accept on the other both take effect in the same edge.

Reset
REQ-027 SHALL, while rst_n is low: clear full flags, wr_cnt, rd_idx, both bank pointers to 0; set the FSM to IDLE; drive dout = 0, dout_idx = 0, dout_last = 0, dout_valid = 0; in_ready = 1 after reset.
REQ-028 SHALL, on reset mid-block, discard partial and buffered blocks; bank contents need no reset.

Structure
REQ-029 SHALL place the zigzag lookup table, N_COEF, and the FSM state encoding in shared package dct_pkg.
REQ-030 SHALL implement the rounding shift in sub-module dct_quant_round (combinational, parameter COEF_W).

Verification
REQ-031 Reset, then 16 writes of raster values 0..15 with qshift = 0, dout_ready = 1 -> dout sequence 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15; dout_last only on the 16th output; first dout_valid 1 cycle after the 16th write.
REQ-032 qshift = 2, coefficients 5, -5, 6, -6, 7, -32768 -> dout 1, -1, 2, -2, 2, -8192.
REQ-033 dout_ready = 0 with 48 writes offered -> exactly 32 accepted, then in_ready = 0; dout held at its first value; raising dout_ready drains both blocks with no gap between dout_idx 15 and the next 0.
REQ-034 Random dout_ready stalls over 4 back-to-back blocks -> no lost or duplicated coefficient; output matches the reference zigzag/quant model.
REQ-035 rst_n pulsed low after 9 writes -> dout_valid = 0 and in_ready = 1 immediately; the next 16 writes form a fresh block.
REQ-036 qshift changed from 1 to 3 at output index 5 -> all 16 outputs of that block quantised with shift 1.
